// File: rtl/fb_pixel_write_if.sv
// Pixel-stream, clear-control and framebuffer write-port bundle for fb_pixel_write.
// The master side is the renderer/controller environment; the slave side is the write stage.
interface fb_pixel_write_if #(
    parameter int unsigned CORDW = 16,
    parameter int unsigned CIDXW = 4,
    parameter int unsigned ADDRW = 16
);
    // renderer pixel stream and throttle
    logic                    draw_en;
    logic signed [CORDW-1:0] x;
    logic signed [CORDW-1:0] y;
    logic        [CIDXW-1:0] cidx;
    logic                    drawing;
    logic                    oe;

    // full-screen fill control
    logic                    clear_start;
    logic        [CIDXW-1:0] clear_cidx;
    logic                    clear_busy;
    logic                    clear_done;

    // framebuffer BRAM write port
    logic                    fb_we;
    logic        [ADDRW-1:0] fb_addr;
    logic        [CIDXW-1:0] fb_cidx;

    modport master (
        output draw_en, x, y, cidx, drawing, clear_start, clear_cidx,
        input  oe, clear_busy, clear_done, fb_we, fb_addr, fb_cidx
    );

    modport slave (
        input  draw_en, x, y, cidx, drawing, clear_start, clear_cidx,
        output oe, clear_busy, clear_done, fb_we, fb_addr, fb_cidx
    );
endinterface

// File: rtl/fb_pixel_write.sv
// Framebuffer write stage: clips renderer pixels, maps (x,y) to a linear address in a
// 3-stage pipeline, and owns a full-screen fill that borrows the write port.
module fb_pixel_write #(
    parameter int unsigned CORDW  = 16,
    parameter int unsigned CIDXW  = 4,
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 180,
    parameter int unsigned ADDRW  = $clog2(WIDTH*HEIGHT)
) (
    input  logic           clk,
    input  logic           rst,
    fb_pixel_write_if.slave bus
);

    localparam int unsigned NPIX   = WIDTH * HEIGHT;
    localparam int unsigned CNTW   = $clog2(NPIX + 1);
    localparam int unsigned DRAINW = 2;

    localparam logic signed [CORDW-1:0] X_LIM     = CORDW'(WIDTH);
    localparam logic signed [CORDW-1:0] Y_LIM     = CORDW'(HEIGHT);
    localparam logic signed [CORDW-1:0] CORD_ZERO = '0;
    localparam logic        [CNTW-1:0]  FILL_END  = CNTW'(NPIX);
    localparam logic        [DRAINW-1:0] DRAIN_LOAD = DRAINW'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_e;

    // control state
    state_e              state_q,      state_d;
    logic [DRAINW-1:0]   drain_cnt_q,  drain_cnt_d;
    logic [CNTW-1:0]     fill_cnt_q,   fill_cnt_d;
    logic [CIDXW-1:0]    fill_cidx_q,  fill_cidx_d;
    logic                clear_busy_q, clear_busy_d;
    logic                clear_done_q, clear_done_d;

    // pipeline stage 1
    logic signed [CORDW-1:0] x1_q,    x1_d;
    logic signed [CORDW-1:0] y1_q,    y1_d;
    logic        [CIDXW-1:0] cidx1_q, cidx1_d;
    logic                    v1_q,    v1_d;

    // pipeline stage 2
    logic        [ADDRW-1:0] row2_q,  row2_d;
    logic signed [CORDW-1:0] x2_q,    x2_d;
    logic        [CIDXW-1:0] cidx2_q, cidx2_d;
    logic                    v2_q,    v2_d;

    // shared write-port registers (stage 3 / fill counter)
    logic                    fb_we_q,   fb_we_d;
    logic        [ADDRW-1:0] fb_addr_q, fb_addr_d;
    logic        [CIDXW-1:0] fb_cidx_q, fb_cidx_d;

    logic oe_int;
    logic in_bounds;

    assign oe_int = bus.draw_en && (state_q == IDLE);

    // clear sequencer; CLEAR keeps one tail cycle so the last fill write is on the bus
    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        fill_cnt_d   = fill_cnt_q;
        fill_cidx_d  = fill_cidx_q;

        unique case (state_q)
            IDLE: begin
                if (bus.clear_start) begin
                    fill_cidx_d = bus.clear_cidx;
                    drain_cnt_d = DRAIN_LOAD;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == '0) begin
                    fill_cnt_d = '0;
                    state_d    = CLEAR;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAINW'(1);
                end
            end
            CLEAR: begin
                if (fill_cnt_q == FILL_END) begin
                    state_d = DONE;
                end else begin
                    fill_cnt_d = fill_cnt_q + CNTW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        clear_busy_d = (state_d == DRAIN) || (state_d == CLEAR);
        clear_done_d = (state_d == DONE);
    end

    // pixel pipeline and write-port source select
    always_comb begin
        in_bounds = (bus.x >= CORD_ZERO) && (bus.x < X_LIM) &&
                    (bus.y >= CORD_ZERO) && (bus.y < Y_LIM);

        x1_d    = bus.x;
        y1_d    = bus.y;
        cidx1_d = bus.cidx;
        v1_d    = bus.drawing && oe_int && in_bounds;

        row2_d  = ADDRW'($unsigned(y1_q)) * ADDRW'(WIDTH);
        x2_d    = x1_q;
        cidx2_d = cidx1_q;
        v2_d    = v1_q;

        if (state_q == CLEAR) begin
            fb_we_d   = (fill_cnt_q != FILL_END);
            fb_addr_d = ADDRW'(fill_cnt_q);
            fb_cidx_d = fill_cidx_q;
        end else begin
            fb_we_d   = v2_q;
            fb_addr_d = row2_q + ADDRW'($unsigned(x2_q));
            fb_cidx_d = cidx2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            drain_cnt_q  <= '0;
            fill_cnt_q   <= '0;
            fill_cidx_q  <= '0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
            x1_q         <= '0;
            y1_q         <= '0;
            cidx1_q      <= '0;
            v1_q         <= 1'b0;
            row2_q       <= '0;
            x2_q         <= '0;
            cidx2_q      <= '0;
            v2_q         <= 1'b0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_cidx_q    <= '0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            fill_cnt_q   <= fill_cnt_d;
            fill_cidx_q  <= fill_cidx_d;
            clear_busy_q <= clear_busy_d;
            clear_done_q <= clear_done_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
            cidx1_q      <= cidx1_d;
            v1_q         <= v1_d;
            row2_q       <= row2_d;
            x2_q         <= x2_d;
            cidx2_q      <= cidx2_d;
            v2_q         <= v2_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_cidx_q    <= fb_cidx_d;
        end
    end

    assign bus.oe         = oe_int;
    assign bus.clear_busy = clear_busy_q;
    assign bus.clear_done = clear_done_q;
    assign bus.fb_we      = fb_we_q;
    assign bus.fb_addr    = fb_addr_q;
    assign bus.fb_cidx    = fb_cidx_q;

endmodule
